// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM round-robin arbiter.
// Holds the requester-ID width rule and the rotate-and-find-first search.
package spram_arb_pkg;

  localparam int unsigned MAX_REQ   = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

  // First set bit of req scanning ptr, ptr+1, ... wrapping modulo n.
  function automatic rr_pick_t rr_find_first(input logic [MAX_REQ-1:0]   req,
                                             input logic [MAX_IDX_W-1:0] ptr,
                                             input int unsigned          n);
    rr_pick_t    pick;
    int unsigned pos;
    pick = '0;
    pos  = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= n) pos = pos - n;
      if ((i < n) && !pick.found && req[pos[MAX_IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = pos[MAX_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: request vector plus priority pointer
// to a one-hot grant and its encoded index.
module rr_grant
  import spram_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] idx_c,
  output logic          found_c
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_find_first(MAX_REQ'(req), MAX_IDX_W'(ptr), N);
    found_c = pick.found;
    idx_c   = IW'(pick.idx);
    grant_c = pick.found ? (N'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/single_port_ram_rden.sv
// Single-port RAM with read enable; the read address register only loads
// on re, so q tracks the last read address including later writes to it.
module single_port_ram_rden #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) addr_q <= addr;
  end

  assign q = mem[addr_q];

endmodule

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters,
// one access per cycle, read data returned one cycle later with its ID.
module spram_rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 2,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned ADDR_WIDTH = 6,
  localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [DATA_WIDTH-1:0]            rsp_rdata
);

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       ptr_nxt;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       g;
  logic                  found;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  ram_we;
  logic                  ram_re;

  rr_grant #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_grant (
    .req     (req_valid),
    .ptr     (ptr),
    .grant_c (grant),
    .idx_c   (g),
    .found_c (found)
  );

  // State register: priority pointer and read-response pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (found) ptr <= ptr_nxt;
      rsp_valid <= found & ~sel_we;
      if (found & ~sel_we) rsp_id <= g;
    end
  end

  // Next pointer: one past the winner, wrapping at NUM_REQ.
  always_comb begin
    ptr_nxt = '0;
    if (32'(g) != NUM_REQ - 1) ptr_nxt = g + ID_W'(1);
  end

  // Winner's request steered onto the RAM port; writes suppressed in reset.
  always_comb begin
    sel_we    = |(req_we & grant);
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ram_we    = sel_we & ~rst;
    ram_re    = found & ~sel_we;
    req_ready = grant;
  end

  single_port_ram_rden #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (sel_addr),
    .wdata (sel_wdata),
    .q     (rsp_rdata)
  );

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Scoreboard bench for spram_rr_arbiter: a 2-requester instance for the
// main scenarios and a 4-requester instance for rotation fairness.
module tb_spram_rr_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  logic rst;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic             rsp_valid;
  logic [0:0]       rsp_id;
  logic [DW-1:0]    rsp_rdata;

  logic [3:0]    v4;
  logic [3:0]    we4;
  logic [4*AW-1:0] addr4;
  logic [4*DW-1:0] wdata4;
  logic [3:0]    ready4;
  logic          rsp_valid4;
  logic [1:0]    rsp_id4;
  logic [DW-1:0] rdata4;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] mem_m [64];
  int         ptr_m = 0;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spram_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata)
  );

  spram_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_we(we4),
    .req_addr(addr4), .req_wdata(wdata4), .req_ready(ready4),
    .rsp_valid(rsp_valid4), .rsp_id(rsp_id4), .rsp_rdata(rdata4)
  );

  // Response monitor: every rsp_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        miscompares++;
        $display("FAIL rsp_unexpected cyc=%0d got id=%0d data=%h, required no response",
                 cyc, rsp_id, rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_id !== 1'(mon_e.id) || rsp_rdata !== mon_e.data) begin
          miscompares++;
          $display("FAIL rsp_data cyc=%0d got id=%0d data=%h, required id=%0d data=%h",
                   cyc, rsp_id, rsp_rdata, mon_e.id, mon_e.data);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL rsp_missing cyc=%0d got rsp_valid=%b, required id=%0d data=%h",
               cyc, rsp_valid, exp_q[0].id, exp_q[0].data);
      void'(exp_q.pop_front());
    end
  end

  function automatic logic [NR-1:0] rr_model(input logic [NR-1:0] v, input int p);
    int idx;
    for (int i = 0; i < int'(NR); i++) begin
      idx = (p + i) % int'(NR);
      if (v[idx]) return NR'(1) << idx;
    end
    return '0;
  endfunction

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_we[i]             = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // One cycle: check the grant against the model, record the transfer.
  task automatic step();
    logic [NR-1:0] exp_g;
    int            g;
    logic [AW-1:0] a;
    exp_t          e;
    @(negedge clk);
    exp_g = rr_model(req_valid, ptr_m);
    vectors++;
    if (req_ready !== exp_g) begin
      miscompares++;
      $display("FAIL grant cyc=%0d got %b, required %b", cyc, req_ready, exp_g);
    end
    if (exp_g != '0 && rst !== 1'b1) begin
      g = exp_g[1] ? 1 : 0;
      a = req_addr[g*AW +: AW];
      if (req_we[g]) begin
        mem_m[a] = req_wdata[g*DW +: DW];
      end else begin
        e.id = g; e.data = mem_m[a]; e.due = cyc + 1;
        exp_q.push_back(e);
      end
      ptr_m = (g + 1) % int'(NR);
    end
    if (rst === 1'b1) ptr_m = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors += 3;
    if (rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_rsp_valid got %b, required 0", rsp_valid);
    end
    if (rsp_id !== 1'b0) begin
      miscompares++; $display("FAIL reset_rsp_id got %b, required 0", rsp_id);
    end
    if (req_ready !== 2'b00) begin
      miscompares++; $display("FAIL reset_idle_ready got %b, required 00", req_ready);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 6'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 6'd0, 8'h00);
    step();
    rst = 1'b0;
    clear_req();
    step();
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 1'b1, 6'd3, 8'hA5);
    step();
    clear_req();
    set_req(1, 1'b1, 1'b0, 6'd3, 8'h00);
    step();
    clear_req();
    step();
  endtask

  task automatic test_alternating();
    set_req(0, 1'b1, 1'b1, 6'd1, 8'h3C);
    step();
    clear_req();
    set_req(1, 1'b1, 1'b1, 6'd2, 8'hC3);
    step();
    set_req(0, 1'b1, 1'b0, 6'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 6'd2, 8'h00);
    for (int i = 0; i < 8; i++) step();
    clear_req();
    step();
  endtask

  task automatic test_read_then_write();
    set_req(0, 1'b1, 1'b1, 6'd5, 8'h11);
    step();
    set_req(0, 1'b1, 1'b0, 6'd5, 8'h00);
    step();
    clear_req();
    set_req(1, 1'b1, 1'b1, 6'd5, 8'h22);
    step();
    clear_req();
    set_req(0, 1'b1, 1'b0, 6'd5, 8'h00);
    step();
    clear_req();
    step();
  endtask

  task automatic test_single_requester();
    set_req(1, 1'b1, 1'b0, 6'd3, 8'h00);
    for (int i = 0; i < 3; i++) step();
    set_req(0, 1'b1, 1'b0, 6'd1, 8'h00);
    step();
    clear_req();
    step();
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b0, 6'd1, 8'h00);
    step();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 6'd1, 8'hEE);
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 6'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 6'd2, 8'h00);
    step();
    set_req(0, 1'b0, 1'b0, 6'd0, 8'h00);
    step();
    clear_req();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 6'd2, 8'h00);
    step();
    rst = 1'b0;
    clear_req();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_read_dropped got rsp_valid=%b, required 0", rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_four_fair();
    int cnt [4];
    logic [3:0] exp4;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    v4 = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp4 = 4'(1) << (k % 4);
      vectors++;
      if (ready4 !== exp4) begin
        miscompares++;
        $display("FAIL fair4_grant k=%0d got %b, required %b", k, ready4, exp4);
      end
      for (int i = 0; i < 4; i++) if (ready4[i] === 1'b1) cnt[i]++;
      if (k > 0) begin
        vectors++;
        if (rsp_valid4 !== 1'b1 || rsp_id4 !== 2'((k - 1) % 4)) begin
          miscompares++;
          $display("FAIL fair4_rsp k=%0d got valid=%b id=%0d, required valid=1 id=%0d",
                   k, rsp_valid4, rsp_id4, (k - 1) % 4);
        end
      end
      @(posedge clk); #1;
    end
    v4 = '0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cnt[i] != 3) begin
        miscompares++;
        $display("FAIL fair4_count id=%0d got %0d grants, required 3", i, cnt[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    v4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_alternating();
    test_read_then_write();
    test_single_requester();
    test_reset_mid();
    test_four_fair();
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout got %0d pending responses, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
